// File: rtl/computer.sv
// SAP-2 style 8-bit machine: multi-cycle CPU, 4 KB program ROM at 0xF000, 4 KB data RAM at 0x0000.
// Control signals are registered by the FSM and act on the datapath one cycle after their state.

module control_unit #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mar_load,
  output logic                  op_load,
  output logic                  temp_load,
  output logic                  pc_inc,
  output logic                  a_from_temp,
  output logic                  b_from_temp,
  output logic                  a_from_alu,
  output logic                  alu_sub,
  output logic                  halt
);

  localparam logic [DATA_WIDTH-1:0] OpHlt  = 'h01;
  localparam logic [DATA_WIDTH-1:0] OpAddB = 'h10;
  localparam logic [DATA_WIDTH-1:0] OpSubB = 'h11;
  localparam logic [DATA_WIDTH-1:0] OpLdiA = 'h20;
  localparam logic [DATA_WIDTH-1:0] OpLdiB = 'h21;

  typedef enum logic [2:0] {
    StInit, StAddr, StRead, StLatch, StChk, StExec1, StExec2, StHalt
  } state_t;

  state_t                  state;
  logic                    byte_idx;
  logic [DATA_WIDTH-1:0]   opcode;
  logic [DATA_WIDTH-1:0]   cur_op;
  logic                    two_byte;

  // During the first-byte check the opcode register is not yet written; decode the read data.
  always_comb begin
    cur_op   = byte_idx ? opcode : mem_data;
    two_byte = (mem_data == OpLdiA) || (mem_data == OpLdiB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StInit;
      byte_idx    <= 1'b0;
      opcode      <= '0;
      mar_load    <= 1'b0;
      op_load     <= 1'b0;
      temp_load   <= 1'b0;
      pc_inc      <= 1'b0;
      a_from_temp <= 1'b0;
      b_from_temp <= 1'b0;
      a_from_alu  <= 1'b0;
      alu_sub     <= 1'b0;
      halt        <= 1'b0;
    end else begin
      mar_load    <= 1'b0;
      op_load     <= 1'b0;
      temp_load   <= 1'b0;
      pc_inc      <= 1'b0;
      a_from_temp <= 1'b0;
      b_from_temp <= 1'b0;
      a_from_alu  <= 1'b0;
      unique case (state)
        StInit: state <= StAddr;
        StAddr: begin
          mar_load <= 1'b1;
          state    <= StRead;
        end
        StRead: state <= StLatch;
        StLatch: begin
          pc_inc <= 1'b1;
          if (byte_idx) temp_load <= 1'b1;
          else          op_load   <= 1'b1;
          state <= StChk;
        end
        StChk: begin
          if (!byte_idx) opcode <= mem_data;
          if (!byte_idx && two_byte) begin
            byte_idx <= 1'b1;
            state    <= StAddr;
          end else begin
            byte_idx <= 1'b0;
            case (cur_op)
              OpHlt: begin
                halt  <= 1'b1;
                state <= StHalt;
              end
              OpAddB, OpSubB, OpLdiA, OpLdiB: state <= StExec1;
              default: state <= StAddr;
            endcase
          end
        end
        StExec1: begin
          state <= StAddr;
          case (opcode)
            OpLdiA: a_from_temp <= 1'b1;
            OpLdiB: b_from_temp <= 1'b1;
            OpAddB, OpSubB: begin
              alu_sub <= (opcode == OpSubB);
              state   <= StExec2;
            end
            default: ;
          endcase
        end
        StExec2: begin
          a_from_alu <= 1'b1;
          state      <= StAddr;
        end
        StHalt: state <= StHalt;
        default: state <= StInit;
      endcase
    end
  end

endmodule

module cpu #(
  parameter int unsigned     DATA_WIDTH = 8,
  parameter int unsigned     ADDR_WIDTH = 16,
  parameter logic [15:0]     ROM_BASE   = 16'hF000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  halt
);

  logic [ADDR_WIDTH-1:0] counter_out;
  logic [DATA_WIDTH-1:0] opcode, temp_1_out, a_out, b_out;
  logic                  flag_zero_o, flag_negative_o, flag_carry_o;
  logic                  mar_load, op_load, temp_load, pc_inc;
  logic                  a_from_temp, b_from_temp, a_from_alu, alu_sub;
  logic [DATA_WIDTH:0]   alu_res;

  control_unit #(.DATA_WIDTH(DATA_WIDTH)) u_control_unit (
    .clk        (clk),
    .reset      (reset),
    .mem_data   (mem_data),
    .mar_load   (mar_load),
    .op_load    (op_load),
    .temp_load  (temp_load),
    .pc_inc     (pc_inc),
    .a_from_temp(a_from_temp),
    .b_from_temp(b_from_temp),
    .a_from_alu (a_from_alu),
    .alu_sub    (alu_sub),
    .halt       (halt)
  );

  // Subtract as A + ~B + 1 so bit 8 is the no-borrow carry.
  always_comb begin
    if (alu_sub) alu_res = {1'b0, a_out} + {1'b0, ~b_out} + {{DATA_WIDTH{1'b0}}, 1'b1};
    else         alu_res = {1'b0, a_out} + {1'b0, b_out};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_out     <= ADDR_WIDTH'(ROM_BASE);
      mem_addr        <= ADDR_WIDTH'(ROM_BASE);
      opcode          <= '0;
      temp_1_out      <= '0;
      a_out           <= '0;
      b_out           <= '0;
      flag_zero_o     <= 1'b0;
      flag_negative_o <= 1'b0;
      flag_carry_o    <= 1'b0;
    end else begin
      if (mar_load)  mem_addr    <= counter_out;
      if (pc_inc)    counter_out <= counter_out + 1'b1;
      if (op_load)   opcode      <= mem_data;
      if (temp_load) temp_1_out  <= mem_data;
      if (a_from_temp) begin
        a_out           <= temp_1_out;
        flag_zero_o     <= (temp_1_out == '0);
        flag_negative_o <= temp_1_out[DATA_WIDTH-1];
      end
      if (b_from_temp) begin
        b_out           <= temp_1_out;
        flag_zero_o     <= (temp_1_out == '0);
        flag_negative_o <= temp_1_out[DATA_WIDTH-1];
      end
      if (a_from_alu) begin
        a_out           <= alu_res[DATA_WIDTH-1:0];
        flag_zero_o     <= (alu_res[DATA_WIDTH-1:0] == '0);
        flag_negative_o <= alu_res[DATA_WIDTH-1];
        flag_carry_o    <= alu_res[DATA_WIDTH];
      end
    end
  end

endmodule

module rom #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [11:0]           addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [0:4095];

  always_ff @(posedge clk) data <= mem[addr];

  task init_sim_rom();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task dump(input logic [11:0] idx, output logic [DATA_WIDTH-1:0] val);
    val = mem[idx];
  endtask

endmodule

module ram #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [11:0]           addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [0:4095];

  always_ff @(posedge clk) data <= mem[addr];

  task init_sim_ram();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

endmodule

module computer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [15:0] ROM_BASE   = 16'hF000
) (
  input  logic clk,
  input  logic reset,
  output logic halt
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data, rom_data, ram_data;
  logic                  sel_rom, sel_ram;

  cpu #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ROM_BASE  (ROM_BASE)
  ) u_cpu (
    .clk     (clk),
    .reset   (reset),
    .mem_data(mem_data),
    .mem_addr(mem_addr),
    .halt    (halt)
  );

  rom #(.DATA_WIDTH(DATA_WIDTH)) u_rom (
    .clk (clk),
    .addr(mem_addr[11:0]),
    .data(rom_data)
  );

  ram #(.DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk (clk),
    .addr(mem_addr[11:0]),
    .data(ram_data)
  );

  // Region select is registered alongside the synchronous memory read data.
  always_ff @(posedge clk) begin
    sel_rom <= (mem_addr[ADDR_WIDTH-1 -: 4] == ROM_BASE[15:12]);
    sel_ram <= (mem_addr[ADDR_WIDTH-1 -: 4] == 4'h0);
  end

  always_comb begin
    mem_data = '0;
    if (sel_rom)      mem_data = rom_data;
    else if (sel_ram) mem_data = ram_data;
  end

endmodule

// File: tb/tb_computer.sv
// Directed program runs; expectations are queued per edge after reset release and checked as
// the run reaches each edge.
module tb_computer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt;

  computer dut (
    .clk  (clk),
    .reset(reset),
    .halt (halt)
  );

  always #5 clk = ~clk;

  localparam int SigOp = 0, SigTmp = 1, SigA = 2, SigB = 3, SigPc = 4;
  localparam int SigZ = 5, SigN = 6, SigC = 7, SigHalt = 8, SigCuOp = 9;

  typedef struct {
    int          edge_n;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passes = 0;
  int   fails = 0;
  int   cur_edge = 0;

  function automatic logic [15:0] obs(input int sig);
    case (sig)
      SigOp:   return {8'h00, dut.u_cpu.opcode};
      SigTmp:  return {8'h00, dut.u_cpu.temp_1_out};
      SigA:    return {8'h00, dut.u_cpu.a_out};
      SigB:    return {8'h00, dut.u_cpu.b_out};
      SigPc:   return dut.u_cpu.counter_out;
      SigZ:    return {15'h0, dut.u_cpu.flag_zero_o};
      SigN:    return {15'h0, dut.u_cpu.flag_negative_o};
      SigC:    return {15'h0, dut.u_cpu.flag_carry_o};
      SigHalt: return {15'h0, halt};
      default: return {8'h00, dut.u_cpu.u_control_unit.opcode};
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      SigOp:   return "opcode";
      SigTmp:  return "temp_1";
      SigA:    return "A";
      SigB:    return "B";
      SigPc:   return "PC";
      SigZ:    return "Z";
      SigN:    return "N";
      SigC:    return "C";
      SigHalt: return "halt";
      default: return "cu_opcode";
    endcase
  endfunction

  task automatic check(input int sig, input logic [15:0] exp);
    logic [15:0] got;
    got = obs(sig);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s @edge %0d: got %h expected %h", sig_name(sig), cur_edge, got, exp);
    end
  endtask

  task automatic push(input int e, input int sig, input logic [15:0] val);
    exp_t x;
    x.edge_n = e;
    x.sig    = sig;
    x.val    = val;
    sb.push_back(x);
  endtask

  task automatic run_to(input int last);
    while (cur_edge < last) begin
      @(posedge clk);
      #1;
      cur_edge++;
      while (sb.size() > 0 && sb[0].edge_n <= cur_edge) begin
        exp_t x;
        x = sb.pop_front();
        check(x.sig, x.val);
      end
    end
  endtask

  task automatic check_reset_state();
    check(SigPc, 16'hF000);
    check(SigA, 16'h0);
    check(SigB, 16'h0);
    check(SigTmp, 16'h0);
    check(SigOp, 16'h0);
    check(SigZ, 16'h0);
    check(SigN, 16'h0);
    check(SigC, 16'h0);
    check(SigHalt, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset    = 1'b0;
    cur_edge = 0;
  endtask

  task automatic load_prog(input logic [7:0] p [7], input int n);
    dut.u_rom.init_sim_rom();
    for (int i = 0; i < n; i++) dut.u_rom.mem[i] = p[i];
  endtask

  task automatic exp_prog1();
    push(5, SigOp, 16'h20);   push(5, SigPc, 16'hF001);
    push(9, SigTmp, 16'h01);  push(9, SigPc, 16'hF002);
    push(11, SigA, 16'h01);   push(11, SigZ, 16'h0);    push(11, SigN, 16'h0);
    push(14, SigOp, 16'h21);
    push(18, SigTmp, 16'hF4);
    push(20, SigB, 16'hF4);   push(20, SigZ, 16'h0);    push(20, SigN, 16'h1);
    push(23, SigOp, 16'h10);
    push(26, SigA, 16'hF5);   push(26, SigZ, 16'h0);    push(26, SigN, 16'h1);
    push(26, SigC, 16'h0);
    push(28, SigHalt, 16'h0);
    push(29, SigCuOp, 16'h01); push(29, SigPc, 16'hF006); push(29, SigHalt, 16'h1);
  endtask

  logic [7:0] prog1 [7];
  logic [7:0] prog2 [7];

  initial begin
    prog1 = '{8'h20, 8'h01, 8'h21, 8'hF4, 8'h10, 8'h01, 8'h00};
    prog2 = '{8'h20, 8'hFF, 8'h21, 8'h01, 8'h10, 8'h11, 8'h01};
    dut.u_ram.init_sim_ram();
    load_prog(prog1, 6);

    // Program 1, then 100 further cycles parked in HALT.
    do_reset();
    exp_prog1();
    push(60, SigPc, 16'hF006);
    push(129, SigPc, 16'hF006);
    push(129, SigHalt, 16'h1);
    run_to(129);

    // Reset in the middle of ADD_B, then an identical re-run.
    do_reset();
    run_to(23);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check(SigPc, 16'hF000);
    check(SigA, 16'h0);
    check(SigN, 16'h0);
    check(SigZ, 16'h0);
    check(SigHalt, 16'h0);
    do_reset();
    exp_prog1();
    run_to(30);

    // Wrap to zero on ADD_B, then borrow on SUB_B.
    reset = 1'b1;
    load_prog(prog2, 7);
    do_reset();
    push(5, SigOp, 16'h20);
    push(11, SigA, 16'hFF);   push(11, SigN, 16'h1);   push(11, SigZ, 16'h0);
    push(20, SigB, 16'h01);   push(20, SigN, 16'h0);   push(20, SigZ, 16'h0);
    push(26, SigA, 16'h00);   push(26, SigZ, 16'h1);   push(26, SigN, 16'h0);
    push(26, SigC, 16'h1);
    push(29, SigOp, 16'h11);
    push(32, SigA, 16'hFF);   push(32, SigZ, 16'h0);   push(32, SigN, 16'h1);
    push(32, SigC, 16'h0);
    push(35, SigCuOp, 16'h01); push(35, SigHalt, 16'h1); push(35, SigPc, 16'hF007);
    run_to(40);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
